// File: rtl/ec_pkg.sv
// Shared types and constants for the echo-cancellation sequencer and its helpers.
package ec_pkg;

  localparam int DW_DEFAULT    = 64;
  localparam int CNT_W_DEFAULT = 13;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONV   = 3'd1,
    ST_ADAPT  = 3'd2,
    ST_CANCEL = 3'd3,
    ST_OUT    = 3'd4
  } ec_state_e;

  // IEEE-754 double encodings of the default step parameters.
  localparam logic [63:0] GAMMA_DEFAULT = 64'h3FD0_0000_0000_0000; // 0.25
  localparam logic [63:0] MU_DEFAULT    = 64'h3FF0_0000_0000_0000; // 1.0

  function automatic logic is_wait_state(input ec_state_e s);
    return (s == ST_CONV) || (s == ST_ADAPT) || (s == ST_CANCEL);
  endfunction

endpackage

// File: rtl/ec_stage_watchdog.sv
// Per-stage cycle counter: cleared on every state entry, flags expiry once the
// stage has spent LIMIT cycles waiting for its ready.
module ec_stage_watchdog #(
  parameter int LIMIT = 1023
) (
  input  logic clk_operation,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && (count != CW'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  // Expiry is the LIMIT-th waiting cycle; the FSM leaves at its closing edge.
  assign expire = tick && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/echo_cancel_sequencer.sv
// Handshake-driven sequencer for the echo-cancellation datapath: convert, adapt
// (training only), cancel, then hand the selected 64-bit result to the output converter.
module echo_cancel_sequencer
  import ec_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEFAULT,
  parameter int TRAIN_SAMPLES = 400,
  parameter int TIMEOUT_CYC   = 1023,
  parameter int ITER_W        = 32,
  parameter int DW            = DW_DEFAULT
) (
  input  logic              clk_operation,
  input  logic              rst,
  input  logic              enable,
  input  logic [CNT_W-1:0]  sampling_cycle_counter,
  input  logic              retrain,
  input  logic              freeze,
  output logic              conv_start,
  input  logic              conv_ready,
  output logic              adapt_start,
  input  logic              adapt_ready,
  output logic              cancel_start,
  input  logic              cancel_ready,
  input  logic [DW-1:0]     e_in,
  input  logic [DW-1:0]     clean_in,
  output logic              out_start,
  output logic [DW-1:0]     out_data,
  output logic              training,
  output logic [ITER_W-1:0] iteration,
  output logic              timeout_err,
  output logic              overrun_err,
  output logic              busy
);

  localparam int TW = $clog2(TRAIN_SAMPLES + 1);
  localparam logic [TW-1:0] TRAIN_INIT = TW'(TRAIN_SAMPLES);

  ec_state_e     state_q, state_d;
  logic [TW-1:0] train_cnt;
  logic          adapted;
  logic          frame_start;
  logic          wd_expire;
  logic          wd_clear;
  logic          conv_start_d, adapt_start_d, cancel_start_d, out_start_d;
  logic          adapt_done, capture_clean, timeout_d;

  assign frame_start = (sampling_cycle_counter == '0);
  assign busy        = (state_q != ST_IDLE);
  assign wd_clear    = (state_d != state_q);

  ec_stage_watchdog #(.LIMIT(TIMEOUT_CYC)) u_watchdog (
    .clk_operation (clk_operation),
    .rst           (rst),
    .clear         (wd_clear),
    .tick          (is_wait_state(state_q)),
    .expire        (wd_expire)
  );

  // Handshake: each *_start is high for exactly the first cycle of its wait
  // state; the matching *_ready is honoured only from the following cycle,
  // so a ready left high by the previous pass cannot complete a new one.
  always_comb begin
    state_d        = state_q;
    conv_start_d   = 1'b0;
    adapt_start_d  = 1'b0;
    cancel_start_d = 1'b0;
    out_start_d    = 1'b0;
    adapt_done     = 1'b0;
    capture_clean  = 1'b0;
    timeout_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && frame_start) begin
          state_d      = ST_CONV;
          conv_start_d = 1'b1;
        end
      end
      ST_CONV: begin
        if (conv_ready && !conv_start) begin
          if (training && !freeze) begin
            state_d       = ST_ADAPT;
            adapt_start_d = 1'b1;
          end else begin
            state_d        = ST_CANCEL;
            cancel_start_d = 1'b1;
          end
        end else if (wd_expire) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      ST_ADAPT: begin
        if (adapt_ready && !adapt_start) begin
          adapt_done     = 1'b1;
          state_d        = ST_CANCEL;
          cancel_start_d = 1'b1;
        end else if (wd_expire) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      ST_CANCEL: begin
        if (cancel_ready && !cancel_start) begin
          capture_clean = !training;
          state_d       = ST_OUT;
          out_start_d   = 1'b1;
        end else if (wd_expire) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      ST_OUT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      conv_start   <= 1'b0;
      adapt_start  <= 1'b0;
      cancel_start <= 1'b0;
      out_start    <= 1'b0;
      out_data     <= '0;
      training     <= 1'b1;
      iteration    <= '0;
      timeout_err  <= 1'b0;
      overrun_err  <= 1'b0;
      train_cnt    <= TRAIN_INIT;
      adapted      <= 1'b0;
    end else begin
      state_q      <= state_d;
      conv_start   <= conv_start_d;
      adapt_start  <= adapt_start_d;
      cancel_start <= cancel_start_d;
      out_start    <= out_start_d;

      if (timeout_d) timeout_err <= 1'b1;
      if (frame_start && (state_q != ST_IDLE)) overrun_err <= 1'b1;

      // Remembers whether this pass adapted, so frozen passes do not count as training.
      if (conv_start_d)       adapted <= 1'b0;
      else if (adapt_start_d) adapted <= 1'b1;

      if (adapt_done) begin
        out_data <= e_in;
        if (iteration != '1) iteration <= iteration + 1'b1;
      end
      if (capture_clean) out_data <= clean_in;

      if (retrain) begin
        training  <= 1'b1;
        train_cnt <= TRAIN_INIT;
      end else if ((state_q == ST_OUT) && training && adapted) begin
        train_cnt <= train_cnt - 1'b1;
        if (train_cnt == TW'(1)) training <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_echo_cancel_sequencer.sv
// Randomized scoreboard bench for echo_cancel_sequencer: a pass-level model
// predicts each out_start's data, iteration and training flag.
module tb_echo_cancel_sequencer;

  localparam int CNT_W     = 8;
  localparam int TRAIN     = 3;
  localparam int TMO       = 15;
  localparam int ITER_W    = 3;
  localparam int DW        = 64;
  localparam int FRAME_LEN = 40;
  localparam int EXP_W     = 1 + ITER_W + DW;

  logic              clk_operation;
  logic              rst;
  logic              enable;
  logic [CNT_W-1:0]  sampling_cycle_counter;
  logic              retrain;
  logic              freeze;
  logic              conv_start, conv_ready;
  logic              adapt_start, adapt_ready;
  logic              cancel_start, cancel_ready;
  logic [DW-1:0]     e_in, clean_in;
  logic              out_start;
  logic [DW-1:0]     out_data;
  logic              training;
  logic [ITER_W-1:0] iteration;
  logic              timeout_err, overrun_err, busy;

  echo_cancel_sequencer #(
    .CNT_W(CNT_W), .TRAIN_SAMPLES(TRAIN), .TIMEOUT_CYC(TMO), .ITER_W(ITER_W), .DW(DW)
  ) dut (
    .clk_operation          (clk_operation),
    .rst                    (rst),
    .enable                 (enable),
    .sampling_cycle_counter (sampling_cycle_counter),
    .retrain                (retrain),
    .freeze                 (freeze),
    .conv_start             (conv_start),
    .conv_ready             (conv_ready),
    .adapt_start            (adapt_start),
    .adapt_ready            (adapt_ready),
    .cancel_start           (cancel_start),
    .cancel_ready           (cancel_ready),
    .e_in                   (e_in),
    .clean_in               (clean_in),
    .out_start              (out_start),
    .out_data               (out_data),
    .training               (training),
    .iteration              (iteration),
    .timeout_err            (timeout_err),
    .overrun_err            (overrun_err),
    .busy                   (busy)
  );

  // ---------------- clock ----------------
  initial begin
    clk_operation = 1'b0;
    forever #5 clk_operation = ~clk_operation;
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  // reference model state (pass granularity)
  logic              m_training;
  int                m_cnt;
  logic [ITER_W-1:0] m_iter;
  logic [DW-1:0]     m_out;
  int                m_conv_pulses = 0;
  int                m_adapt_pulses = 0;
  int                conv_seen = 0;
  int                adapt_seen = 0;

  // per-pass stimulus shared with the responders
  logic [DW-1:0] e_val, clean_val;
  int conv_dly = 2, adapt_dly = 2, cancel_dly = 2;
  bit hold_adapt = 0;
  int conv_pend = 0, adapt_pend = 0, cancel_pend = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- ready responders ----------------
  // Ready stays high through the start-pulse cycle, drops, then returns after the delay.
  always @(negedge clk_operation) begin
    if (conv_start) conv_pend = conv_dly + 1;
    else if (conv_pend > 0) begin
      conv_pend--;
      conv_ready = (conv_pend == 0);
    end
  end

  always @(negedge clk_operation) begin
    if (adapt_start) begin
      adapt_pend = adapt_dly + 1;
      e_in = {$urandom, $urandom};
    end else if (adapt_pend > 0) begin
      if (hold_adapt) adapt_ready = 1'b0;
      else begin
        adapt_pend--;
        adapt_ready = (adapt_pend == 0);
        if (adapt_pend == 0) e_in = e_val;
      end
    end
  end

  always @(negedge clk_operation) begin
    if (cancel_start) begin
      cancel_pend = cancel_dly + 1;
      clean_in = {$urandom, $urandom};
    end else if (cancel_pend > 0) begin
      cancel_pend--;
      cancel_ready = (cancel_pend == 0);
      if (cancel_pend == 0) clean_in = clean_val;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [EXP_W-1:0] mon_e;
  always @(negedge clk_operation) begin
    if (conv_start) conv_seen++;
    if (adapt_start) adapt_seen++;
    if (out_start) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_out_start: got out_start (out_data=%0h) expected none at %0t", out_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", out_data, mon_e[DW-1:0]);
        check("iteration", 64'(iteration), 64'(mon_e[DW +: ITER_W]));
        check("training_at_out", 64'(training), 64'(mon_e[EXP_W-1]));
        check("busy_at_out", 64'(busy), 64'd1);
      end
    end
  end

  // ---------------- model + driver tasks ----------------
  task automatic model_reset();
    m_training = 1'b1;
    m_cnt      = TRAIN;
    m_iter     = '0;
    m_out      = '0;
  endtask

  task automatic issue_pass(input bit retrain_at_out);
    bit adapts;
    e_val      = {$urandom, $urandom};
    clean_val  = {$urandom, $urandom};
    conv_dly   = $urandom_range(1, 6);
    adapt_dly  = $urandom_range(1, 6);
    cancel_dly = $urandom_range(1, 6);
    adapts = m_training && !freeze;
    m_conv_pulses++;
    if (adapts) begin
      m_adapt_pulses++;
      if (m_iter != '1) m_iter = m_iter + 1'b1;
      m_out = e_val;
    end else if (!m_training) begin
      m_out = clean_val;
    end
    exp_q.push_back({m_training, m_iter, m_out});
    if (adapts) begin
      m_cnt--;
      if (m_cnt == 0) m_training = 1'b0;
    end
    if (retrain_at_out) begin
      m_training = 1'b1;
      m_cnt      = TRAIN;
    end
  endtask

  task automatic drive_frame(input int len, input bit retrain_at_out, input bit drop_enable);
    for (int i = 0; i < len; i++) begin
      @(negedge clk_operation);
      sampling_cycle_counter = CNT_W'(i);
      retrain = 1'b0;
      if (retrain_at_out && out_start) retrain = 1'b1;
      if (drop_enable && conv_start) enable = 1'b0;
    end
    @(negedge clk_operation);
    retrain = 1'b0;
  endtask

  task automatic retrain_pulse();
    @(negedge clk_operation);
    retrain = 1'b1;
    @(negedge clk_operation);
    retrain = 1'b0;
    m_training = 1'b1;
    m_cnt      = TRAIN;
    check("training_after_retrain", 64'(training), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit rao;
    rst = 1'b1;
    enable = 1'b1;
    sampling_cycle_counter = CNT_W'(1);
    retrain = 1'b0;
    freeze = 1'b0;
    conv_ready = 1'b1;
    adapt_ready = 1'b1;
    cancel_ready = 1'b1;
    e_in = '0;
    clean_in = '0;
    model_reset();

    #2 rst = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_conv_start", 64'(conv_start), 64'd0);
    check("rst_adapt_start", 64'(adapt_start), 64'd0);
    check("rst_cancel_start", 64'(cancel_start), 64'd0);
    check("rst_out_start", 64'(out_start), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_training", 64'(training), 64'd1);
    check("rst_iteration", 64'(iteration), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    check("rst_overrun_err", 64'(overrun_err), 64'd0);
    repeat (3) @(negedge clk_operation);
    rst = 1'b1;

    // freeze from reset: no adaptation, training held
    freeze = 1'b1;
    for (int f = 0; f < 2; f++) begin
      issue_pass(1'b0);
      drive_frame(FRAME_LEN, 1'b0, 1'b0);
    end
    check("freeze_adapt_pulses", 64'(adapt_seen), 64'd0);
    check("freeze_training", 64'(training), 64'd1);
    freeze = 1'b0;

    // training passes, then normal passes
    for (int f = 0; f < 5; f++) begin
      issue_pass(1'b0);
      drive_frame(FRAME_LEN, 1'b0, 1'b0);
    end
    check("trained_training", 64'(training), 64'd0);
    check("trained_iteration", 64'(iteration), 64'd3);

    // retrain, one adapting pass, then a timed-out adapt stage
    retrain_pulse();
    issue_pass(1'b0);
    drive_frame(FRAME_LEN, 1'b0, 1'b0);
    check("pre_timeout_err", 64'(timeout_err), 64'd0);
    conv_dly = 2;
    hold_adapt = 1;
    m_conv_pulses++;
    m_adapt_pulses++;
    drive_frame(FRAME_LEN, 1'b0, 1'b0);
    hold_adapt = 0;
    check("timeout_err", 64'(timeout_err), 64'd1);
    check("timeout_idle", 64'(busy), 64'd0);

    // retrain arriving with the final decrement keeps training alive
    issue_pass(1'b0);
    drive_frame(FRAME_LEN, 1'b0, 1'b0);
    issue_pass(1'b1);
    drive_frame(FRAME_LEN, 1'b1, 1'b0);
    check("retrain_wins_training", 64'(training), 64'd1);
    for (int f = 0; f < 3; f++) begin
      issue_pass(1'b0);
      drive_frame(FRAME_LEN, 1'b0, 1'b0);
    end
    check("retrained_training", 64'(training), 64'd0);
    check("iteration_saturated", 64'(iteration), 64'd7);

    // frame start while in CANCEL
    check("pre_overrun_err", 64'(overrun_err), 64'd0);
    issue_pass(1'b0);
    cancel_dly = 12;
    for (int i = 0; i < FRAME_LEN; i++) begin
      @(negedge clk_operation);
      sampling_cycle_counter = CNT_W'(i);
      if (cancel_start) break;
    end
    repeat (3) @(negedge clk_operation);
    drive_frame(FRAME_LEN, 1'b0, 1'b0);
    check("overrun_err", 64'(overrun_err), 64'd1);
    issue_pass(1'b0);
    drive_frame(FRAME_LEN, 1'b0, 1'b0);

    // enable dropped mid-pass: pass completes, next frame idle
    issue_pass(1'b0);
    drive_frame(FRAME_LEN, 1'b0, 1'b1);
    drive_frame(FRAME_LEN, 1'b0, 1'b0);
    check("disabled_idle", 64'(busy), 64'd0);
    enable = 1'b1;

    // randomized mix
    for (int f = 0; f < 14; f++) begin
      if ($urandom_range(0, 5) == 0) retrain_pulse();
      freeze = ($urandom_range(0, 3) == 0);
      rao = ($urandom_range(0, 7) == 0);
      issue_pass(rao);
      drive_frame(FRAME_LEN, rao, 1'b0);
    end
    freeze = 1'b0;

    // asynchronous reset while in ADAPT
    retrain_pulse();
    conv_dly = 2;
    hold_adapt = 1;
    m_conv_pulses++;
    m_adapt_pulses++;
    for (int i = 0; i < FRAME_LEN; i++) begin
      @(negedge clk_operation);
      sampling_cycle_counter = CNT_W'(i);
      if (adapt_start) break;
    end
    @(negedge clk_operation);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out_data", out_data, 64'd0);
    check("abort_training", 64'(training), 64'd1);
    check("abort_iteration", 64'(iteration), 64'd0);
    check("abort_timeout_err", 64'(timeout_err), 64'd0);
    check("abort_overrun_err", 64'(overrun_err), 64'd0);
    hold_adapt = 0;
    model_reset();
    exp_q.delete();
    @(negedge clk_operation);
    sampling_cycle_counter = CNT_W'(1);
    rst = 1'b1;
    issue_pass(1'b0);
    drive_frame(FRAME_LEN, 1'b0, 1'b0);

    check("leftover_expected", 64'(exp_q.size()), 64'd0);
    check("conv_pulse_count", 64'(conv_seen), 64'(m_conv_pulses));
    check("adapt_pulse_count", 64'(adapt_seen), 64'(m_adapt_pulses));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/echo_cancel_sequencer.md
Name: echo_cancel_sequencer

Overview:
- Handshake-driven control FSM for the double-precision echo-cancellation datapath: converters, parameter approximator, canceller, output converter.
- Replaces fixed-delay sequencing with start/ready handshakes, per-stage timeouts and a parametrised training length.
- Supports runtime retrain and a freeze mode, and selects which 64-bit result feeds the output converter.
- Sits in the top level; the arithmetic sub-blocks stay unchanged.

Parameters:
- CNT_W, 13, width of sampling_cycle_counter
- TRAIN_SAMPLES, 400, sample periods spent adapting after reset or retrain (must be >= 1)
- TIMEOUT_CYC, 1023, max clk_operation cycles waited for any single ready
- ITER_W, 32, width of the iteration counter (saturating)
- DW, 64, result data width (IEEE double)

Ports:
- clk_operation  in  1  operation clock
- rst  in  1  asynchronous reset, active-low (asserted at 0)
- enable  in  1  sample processing allowed; sampled only in IDLE
- sampling_cycle_counter  in  CNT_W  frame position; value 0 marks the frame start
- retrain  in  1  1-cycle pulse that restarts the training phase
- freeze  in  1  level; while 1, the ADAPT stage is skipped even in training
- conv_start  out  1  1-cycle pulse to both 16b->double converters
- conv_ready  in  1  AND of both converter ready signals
- adapt_start  out  1  1-cycle pulse to the parameter approximator
- adapt_ready  in  1  approximator ready
- cancel_start  out  1  1-cycle pulse to the canceller
- cancel_ready  in  1  canceller ready
- e_in  in  DW  adaptation error
- clean_in  in  DW  echo-cancelled signal
- out_start  out  1  1-cycle pulse to the double->16b converter
- out_data  out  DW  registered value for the output converter
- training  out  1  1 while in the training phase
- iteration  out  ITER_W  completed adapt passes
- timeout_err  out  1  sticky stage-timeout flag
- overrun_err  out  1  sticky missed-frame flag
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; all pulses 0; out_data=0; training=1; iteration=0; timeout_err=0; overrun_err=0; busy=0; train_cnt=TRAIN_SAMPLES; watchdog=0.
- States: IDLE, CONV, ADAPT, CANCEL, OUT.
- IDLE -> CONV when enable=1 and sampling_cycle_counter==0. conv_start pulses on the transition edge.
- Each wait state checks its ready starting the cycle after the start pulse. A ready already high on the pulse cycle is ignored.
- CONV: on conv_ready, go to ADAPT (training=1 and freeze=0; pulse adapt_start) or to CANCEL (pulse cancel_start).
- ADAPT: on adapt_ready:
  - iteration increments, saturating at all-ones.
  - out_data <= e_in.
  - Go to CANCEL and pulse cancel_start.
- CANCEL: on cancel_ready:
  - out_data <= clean_in if training=0; otherwise out_data keeps e_in.
  - Go to OUT.
- OUT: out_start pulses 1 cycle; go to IDLE.
  - If training=1, train_cnt decrements. At 1->0, training clears on the next cycle.
- Latency: frame start to out_start = 3 + (conv, adapt, cancel handshake cycles) for an adapting pass.
- Watchdog clears on each state entry and counts in wait states. When it reaches TIMEOUT_CYC:
  - timeout_err is set and the state goes to IDLE.
  - No out_start for that frame; out_data holds.
- sampling_cycle_counter==0 while state!=IDLE: overrun_err set; the current pass continues and no new pass starts for that frame.
- retrain pulse: training=1, train_cnt=TRAIN_SAMPLES; an in-flight pass continues unchanged. If retrain coincides with the final train_cnt decrement, retrain wins.
- freeze=1 during training: adapt is skipped and train_cnt does not decrement. iteration is unchanged.
- enable deasserted mid-pass: the pass completes; no new pass starts.
- Reset mid-pass: immediate abort to reset values.

Decomposition:
- Shared package ec_pkg:
  - state enum
  - DW and CNT_W defaults
  - double constants GAMMA_DEFAULT (0.25) and MU_DEFAULT (1.0) for top-level use
- Sub-module: ec_stage_watchdog, a counter with clear/expire, reused per wait state.

Test Plan:
- TRAIN_SAMPLES=3, readies return after 5 cycles -> three passes pulse adapt_start with out_data=e_in; iteration=3; training drops; 4th pass has no adapt_start and out_data=clean_in.
- adapt_ready held 0, TIMEOUT_CYC=15 -> timeout_err=1 after 15 wait cycles; FSM in IDLE; no out_start; next frame starts normally.
- Frame start reasserted while in CANCEL -> overrun_err=1; exactly one out_start for that pass.
- After training, retrain pulse -> training=1; next 3 passes adapt; iteration increments by 3.
- freeze=1 from reset for 2 frames -> adapt_start never pulses; iteration=0; training stays 1.
- rst=0 while in ADAPT -> all outputs return to reset values asynchronously; the first frame after release starts at CONV.
